clock_divider_multi_channel: RTL and testbench

//  Parametrised N-channel programmable clock divider; successor to the fixed 100 MHz->1 Hz divider.

---
 rtl/clock_divider_multi_channel.sv | 59 +++++
 tb/tb_clock_divider_multi_channel.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi_channel.sv
// N-channel programmable 50%-duty clock divider with per-channel tick, enable and
// a global phase-align strobe. Half-period changes are latched only at boundaries.
module clock_divider_multi_channel #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 27
) (
  input  logic                      Clock_100MHz,
  input  logic                      Clear_n,
  input  logic                      Sync,
  input  logic [NUM_CH-1:0]         Enable,
  input  logic [NUM_CH*CNT_W-1:0]   Half_Period,
  output logic [NUM_CH-1:0]         Clock_Out,
  output logic [NUM_CH-1:0]         Tick
);

  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [CNT_W-1:0]  r_act [NUM_CH];
  logic [NUM_CH-1:0] r_clk;
  logic [NUM_CH-1:0] r_tick;

  logic [CNT_W-1:0]  w_hp [NUM_CH];
  logic [NUM_CH-1:0] w_last;

  // A zero half-period behaves as one: the boundary is reached at cnt==0.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_hp[i]   = Half_Period[i*CNT_W +: CNT_W];
      w_last[i] = (r_act[i] == '0) ? (r_cnt[i] == '0)
                                   : (r_cnt[i] == r_act[i] - CNT_W'(1));
    end
  end

  always_ff @(posedge Clock_100MHz) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!Clear_n || Sync) begin
        r_cnt[i]  <= '0;
        r_clk[i]  <= 1'b0;
        r_tick[i] <= 1'b0;
        r_act[i]  <= w_hp[i];
      end else if (Enable[i]) begin
        if (w_last[i]) begin
          r_cnt[i]  <= '0;
          r_clk[i]  <= ~r_clk[i];
          r_tick[i] <= ~r_clk[i];
          r_act[i]  <= w_hp[i];
        end else begin
          r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
          r_tick[i] <= 1'b0;
        end
      end else begin
        r_tick[i] <= 1'b0;
      end
    end
  end

  assign Clock_Out = r_clk;
  assign Tick      = r_tick;

endmodule

// File: tb/tb_clock_divider_multi_channel.sv
// Scoreboard bench: stimulus pushes predicted {Clock_Out,Tick} per edge, monitor pops and compares.
module tb_clock_divider_multi_channel;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CNT_W  = 4;

  logic                    clk;
  logic                    Clear_n;
  logic                    Sync;
  logic [NUM_CH-1:0]       Enable;
  logic [NUM_CH*CNT_W-1:0] Half_Period;
  logic [NUM_CH-1:0]       Clock_Out;
  logic [NUM_CH-1:0]       Tick;

  clock_divider_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .Clock_100MHz (clk),
    .Clear_n      (Clear_n),
    .Sync         (Sync),
    .Enable       (Enable),
    .Half_Period  (Half_Period),
    .Clock_Out    (Clock_Out),
    .Tick         (Tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Expected {Tick, Clock_Out} after each rising edge.
  logic [2*NUM_CH-1:0] exp_q [$];

  // Reference: a channel sits at level m_level, m_pos enabled edges into a half lasting m_len.
  int   m_pos   [NUM_CH];
  int   m_len   [NUM_CH];
  logic m_level [NUM_CH];

  function automatic int eff(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  task automatic step(input logic clr_n, input logic sync, input logic [1:0] en,
                      input int h0, input int h1);
    logic [NUM_CH-1:0] e_clk;
    logic [NUM_CH-1:0] e_tick;
    int hp [NUM_CH];
    @(negedge clk);
    Clear_n     = clr_n;
    Sync        = sync;
    Enable      = en;
    Half_Period = {h1[CNT_W-1:0], h0[CNT_W-1:0]};
    hp[0] = h0;
    hp[1] = h1;
    for (int c = 0; c < NUM_CH; c++) begin
      e_tick[c] = 1'b0;
      if (!clr_n || sync) begin
        m_level[c] = 1'b0;
        m_pos[c]   = 0;
        m_len[c]   = eff(hp[c]);
      end else if (en[c]) begin
        m_pos[c] = m_pos[c] + 1;
        if (m_pos[c] >= m_len[c]) begin
          m_pos[c]   = 0;
          m_level[c] = !m_level[c];
          e_tick[c]  = m_level[c];
          m_len[c]   = eff(hp[c]);
        end
      end
      e_clk[c] = m_level[c];
    end
    exp_q.push_back({e_tick, e_clk});
  endtask

  task automatic run(input int n, input logic [1:0] en, input int h0, input int h1);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, en, h0, h1);
  endtask

  // Monitor: one comparison per rising edge for which a prediction exists.
  initial begin
    logic [2*NUM_CH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({Tick, Clock_Out} !== e) begin
          miscompares++;
          $display("FAIL edge_%0d: Clock_Out=%b Tick=%b, expected Clock_Out=%b Tick=%b (t=%0t)",
                   vectors, Clock_Out, Tick, e[NUM_CH-1:0], e[2*NUM_CH-1:NUM_CH], $time);
        end
      end
    end
  end

  initial begin
    int h0, h1, wait_cyc;
    logic [1:0] en;
    Clear_n = 1'b1; Sync = 1'b0; Enable = '0; Half_Period = '0;

    // Basic: ch0 H=5, ch1 H=1.
    step(1'b0, 1'b0, 2'b11, 5, 1);
    step(1'b0, 1'b0, 2'b11, 5, 1);
    run(40, 2'b11, 5, 1);

    // H=0 acts as 1; max half-period 15.
    step(1'b0, 1'b0, 2'b11, 0, 15);
    run(70, 2'b11, 0, 15);

    // Half-period change mid-half applies from next boundary.
    step(1'b0, 1'b0, 2'b11, 5, 2);
    run(2, 2'b11, 5, 2);
    run(30, 2'b11, 3, 2);

    // Enable freeze mid-half at cnt=3.
    step(1'b0, 1'b0, 2'b11, 5, 3);
    run(3, 2'b11, 5, 3);
    run(7, 2'b10, 5, 3);
    run(20, 2'b11, 5, 3);

    // Sync realigns out-of-phase channels.
    step(1'b0, 1'b0, 2'b11, 4, 6);
    run(7, 2'b11, 4, 6);
    step(1'b1, 1'b1, 2'b11, 4, 6);
    run(30, 2'b11, 4, 6);

    // Clear mid-high-phase, then Clear together with Sync and new half-periods.
    step(1'b0, 1'b0, 2'b11, 5, 1);
    run(7, 2'b11, 5, 1);
    step(1'b0, 1'b0, 2'b11, 5, 1);
    run(20, 2'b11, 5, 1);
    step(1'b0, 1'b1, 2'b11, 3, 2);
    run(20, 2'b11, 3, 2);

    // Randomized traffic.
    h0 = $urandom_range(0, 15);
    h1 = $urandom_range(0, 15);
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 19) == 0) h0 = $urandom_range(0, 15);
      if ($urandom_range(0, 19) == 0) h1 = $urandom_range(0, 15);
      en[0] = ($urandom_range(0, 7) != 0);
      en[1] = ($urandom_range(0, 7) != 0);
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 39) == 0), en, h0, h1);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
